lmult_arb: RTL and testbench

LMULT_ARB -- requirements
Module: lmult_arb

---
 rtl/lmult_pkg.sv | 19 +
 rtl/q15_lmult_core.sv | 14 +
 rtl/lmult_arb.sv | 102 ++++++++++
 tb/tb_lmult_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmult_pkg.sv
// lmult_pkg: shared types, op encodings and saturation helper for the Q15 long-multiply arbiter.
// Exports: NREQ_DEF, op_t, q15_t, q31_t, Q31_MAX, Q31_MIN, sat32().
package lmult_pkg;
    localparam int NREQ_DEF = 4;
    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_MAC  = 2'b01,
        OP_MSU  = 2'b10,
        OP_LOAD = 2'b11
    } op_t;
    typedef logic signed [15:0] q15_t;
    typedef logic signed [31:0] q31_t;
    localparam q31_t Q31_MAX = 32'sh7FFF_FFFF;
    localparam q31_t Q31_MIN = 32'sh8000_0000;
    // Overflow shows up as the two top bits of the 33-bit sum disagreeing.
    function automatic q31_t sat32(input logic signed [32:0] x);
        return (x[32] == x[31]) ? q31_t'(x[31:0]) : (x[32] ? Q31_MIN : Q31_MAX);
    endfunction
endpackage

// File: rtl/q15_lmult_core.sv
// q15_lmult_core: combinational Q15 x Q15 -> Q31 fractional multiply with the -1 * -1 corner clamped.
// Ports: a, b - Q15 operands; l - Q31 product.
module q15_lmult_core
    import lmult_pkg::*;
(
    input  q15_t a,
    input  q15_t b,
    output q31_t l
);
    q31_t p;
    assign p = a * b;
    // Only 0x8000 * 0x8000 gives 2^30, whose doubling would wrap to Q31_MIN.
    assign l = (p == 32'sh4000_0000) ? Q31_MAX : q31_t'(p <<< 1);
endmodule

// File: rtl/lmult_arb.sv
// lmult_arb: round-robin arbiter feeding a shared 2-stage Q15 multiply / per-requester accumulate pipeline.
// Ports: clk, rst_n (sync, active-low);
//        req_valid/req_ready per requester, req_a/req_b Q15 operands, req_op (MULT/MAC/MSU/LOAD);
//        res_valid/res_ready result handshake, res_data Q31 result, res_id originating requester.
module lmult_arb
    import lmult_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][15:0] req_a,
    input  logic [NREQ-1:0][15:0] req_b,
    input  logic [NREQ-1:0][1:0]  req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [IW-1:0]         res_id
);
    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NREQ);
    endfunction

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt;
    logic          any;
    logic          adv;
    logic          xfer;
    logic          run;
    q31_t          l;
    logic          s1_valid;
    q31_t          s1_l;
    logic [IW-1:0] s1_id;
    op_t           s1_op;
    q31_t          acc [NREQ];
    q31_t          acc_cur;
    q31_t          acc_nxt;

    // Scan downward from ptr+NREQ-1 so the requester closest to ptr wins last.
    always_comb begin
        gnt = ptr;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap(int'(ptr) + k)]) begin
                gnt = wrap(int'(ptr) + k);
                any = 1'b1;
            end
        end
    end

    assign adv       = !res_valid || res_ready;
    // run holds off grants for the cycle right after a reset edge.
    assign xfer      = run && any && adv;
    assign req_ready = xfer ? (NREQ'(1) << gnt) : '0;

    q15_lmult_core u_core (
        .a (q15_t'(req_a[gnt])),
        .b (q15_t'(req_b[gnt])),
        .l (l)
    );

    // Accumulator update happens in S2, so consecutive ops on one id chain without stalling.
    assign acc_cur = acc[s1_id];
    assign acc_nxt = (s1_op == OP_LOAD) ? s1_l :
                     (s1_op == OP_MSU)  ? sat32({acc_cur[31], acc_cur} - {s1_l[31], s1_l}) :
                                          sat32({acc_cur[31], acc_cur} + {s1_l[31], s1_l});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run       <= 1'b0;
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_l      <= '0;
            s1_id     <= '0;
            s1_op     <= OP_MULT;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            for (int i = 0; i < NREQ; i++) acc[i] <= '0;
        end else begin
            run <= 1'b1;
            if (xfer) ptr <= wrap(int'(gnt) + 1);
            if (adv) begin
                s1_valid  <= xfer;
                res_valid <= s1_valid;
                if (xfer) begin
                    s1_l  <= l;
                    s1_id <= gnt;
                    s1_op <= op_t'(req_op[gnt]);
                end
                if (s1_valid) begin
                    res_data <= (s1_op == OP_MULT) ? s1_l : acc_nxt;
                    res_id   <= s1_id;
                    if (s1_op != OP_MULT) acc[s1_id] <= acc_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_lmult_arb.sv
// tb_lmult_arb: self-checking bench for lmult_arb -- directed vector table, multi-cycle sequences, randomized scoreboard.
module tb_lmult_arb;
    import lmult_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [3:0][15:0] req_a = '0;
    logic [3:0][15:0] req_b = '0;
    logic [3:0][1:0] req_op = '0;
    logic            res_valid;
    logic            res_ready = 1'b1;
    logic [31:0]     res_data;
    logic [1:0]      res_id;

    always #5 clk = ~clk;

    lmult_arb #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  id;
    } exp_t;

    vec_t vt[12];

    // Behavioural reference: fractional multiply and clamp in plain integer arithmetic.
    function automatic logic [31:0] m_lmul(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        if (p == 64'sd1073741824) return 32'h7FFF_FFFF;
        return 32'(p * 2);
    endfunction

    function automatic logic [31:0] m_sat(input longint x);
        if (x > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return 32'(x);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'h0);
        chk("rv_after_rst", 32'(res_valid), 32'h0);
        req_valid = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        @(negedge clk);
        req_valid = 4'(1 << v.id);
        req_op[v.id] = v.op;
        req_a[v.id] = v.a;
        req_b[v.id] = v.b;
        #1;
        chk($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(1 << v.id));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk($sformatf("vec%0d_lat1", n), 32'(res_valid), 32'h0);
        @(negedge clk);
        #1;
        chk($sformatf("vec%0d_valid", n), 32'(res_valid), 32'h1);
        chk($sformatf("vec%0d_data", n), res_data, v.exp);
        chk($sformatf("vec%0d_id", n), 32'(res_id), 32'(v.id));
    endtask

    logic [31:0] acc_m [4];
    int          ptr_m;
    bit          m_s1;
    bit          m_s2;
    exp_t        q[$];

    initial begin
        vt[0]  = '{2'd0, 2'd0, 16'h4000, 16'h4000, 32'h2000_0000};
        vt[1]  = '{2'd0, 2'd0, 16'h8000, 16'h8000, 32'h7FFF_FFFF};
        vt[2]  = '{2'd0, 2'd0, 16'h8000, 16'h7FFF, 32'h8001_0000};
        vt[3]  = '{2'd2, 2'd3, 16'h7FFF, 16'h7FFF, 32'h7FFE_0002};
        vt[4]  = '{2'd2, 2'd1, 16'h4000, 16'h4000, 32'h7FFF_FFFF};
        vt[5]  = '{2'd2, 2'd2, 16'h7FFF, 16'h7FFF, 32'h0001_FFFD};
        vt[6]  = '{2'd1, 2'd3, 16'h8000, 16'h7FFF, 32'h8001_0000};
        vt[7]  = '{2'd1, 2'd2, 16'h7FFF, 16'h7FFF, 32'h8000_0000};
        vt[8]  = '{2'd1, 2'd1, 16'h4000, 16'h4000, 32'hA000_0000};
        vt[9]  = '{2'd3, 2'd0, 16'hFFFF, 16'h0001, 32'hFFFF_FFFE};
        vt[10] = '{2'd3, 2'd1, 16'h0000, 16'h1234, 32'h0000_0000};
        vt[11] = '{2'd3, 2'd0, 16'h7FFF, 16'h7FFF, 32'h7FFE_0002};

        do_reset();
        for (int i = 0; i < 12; i++) apply_vec(vt[i], i);

        // Round robin with every requester asserting.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req_valid = '1;
                for (int i = 0; i < 4; i++) begin
                    req_op[i] = 2'd0;
                    req_a[i] = 16'h4000;
                    req_b[i] = 16'(16'h1000 * (i + 1));
                end
            end
            if (c == 5) req_valid = '0;
            #1;
            if (c < 5) chk($sformatf("rr_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("rr_valid%0d", c), 32'(res_valid), 32'h1);
                chk($sformatf("rr_id%0d", c), 32'(res_id), 32'((c - 2) % 4));
                chk($sformatf("rr_data%0d", c), res_data, 32'h0800_0000 * 32'((c - 2) % 4 + 1));
            end
        end

        // Backpressure: two ops in flight, five stalled cycles.
        do_reset();
        res_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b0001;
        req_op[0] = 2'd0; req_a[0] = 16'h4000; req_b[0] = 16'h4000;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0010;
        req_op[1] = 2'd3; req_a[1] = 16'h4000; req_b[1] = 16'h2000;
        #1;
        chk("bp_ready1", 32'(req_ready), 32'h2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            req_op[3] = 2'd0; req_a[3] = 16'h0001; req_b[3] = 16'h0001;
            #1;
            chk($sformatf("bp_stall_ready%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp_stall_valid%0d", c), 32'(res_valid), 32'h1);
            chk($sformatf("bp_stall_data%0d", c), res_data, 32'h2000_0000);
            chk($sformatf("bp_stall_id%0d", c), 32'(res_id), 32'h0);
        end
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        #1;
        chk("bp_rel_data0", res_data, 32'h2000_0000);
        @(negedge clk);
        #1;
        chk("bp_rel_valid1", 32'(res_valid), 32'h1);
        chk("bp_rel_data1", res_data, 32'h1000_0000);
        chk("bp_rel_id1", 32'(res_id), 32'h1);
        @(negedge clk);
        #1;
        chk("bp_bubble", 32'(res_valid), 32'h0);
        apply_vec('{2'd1, 2'd1, 16'h0000, 16'h0000, 32'h1000_0000}, 100);

        // Reset while a MAC sits in S1.
        @(negedge clk);
        req_valid = 4'b0010;
        req_op[1] = 2'd1; req_a[1] = 16'h4000; req_b[1] = 16'h4000;
        #1;
        chk("mr_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_rv0", 32'(res_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("mr_rv1", 32'(res_valid), 32'h0);
        @(negedge clk);
        req_valid = 4'b1010;
        req_op[3] = 2'd1; req_a[3] = 16'h4000; req_b[3] = 16'h4000;
        #1;
        chk("mr_ptr0", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mr_lat", 32'(res_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("mr_valid", 32'(res_valid), 32'h1);
        chk("mr_acc0", res_data, 32'h2000_0000);
        chk("mr_id", 32'(res_id), 32'h1);

        // Randomized traffic against the scoreboard model.
        do_reset();
        for (int i = 0; i < 4; i++) acc_m[i] = '0;
        ptr_m = 0;
        m_s1 = 0;
        m_s2 = 0;
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int   g;
            bit   any;
            bit   adv_m;
            logic [31:0] l;
            logic [31:0] d;
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                req_op[i] = 2'($urandom_range(0, 3));
                req_a[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                req_b[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if (cyc >= 2990) begin
                req_valid = '0;
                res_ready = 1'b1;
            end
            #1;
            g = 0;
            any = 0;
            for (int k = 0; k < 4; k++) begin
                if (!any && req_valid[(ptr_m + k) % 4]) begin
                    g = (ptr_m + k) % 4;
                    any = 1;
                end
            end
            adv_m = !m_s2 || res_ready;
            chk("rnd_ready", 32'(req_ready), (any && adv_m) ? 32'(1 << g) : 32'h0);
            chk("rnd_valid", 32'(res_valid), 32'(m_s2));
            if (m_s2 && q.size() > 0) begin
                chk("rnd_data", res_data, q[0].d);
                chk("rnd_id", 32'(res_id), 32'(q[0].id));
            end
            if (m_s2 && res_ready && q.size() > 0) void'(q.pop_front());
            if (adv_m) begin
                m_s2 = m_s1;
                m_s1 = any;
                if (any) begin
                    l = m_lmul(req_a[g], req_b[g]);
                    case (req_op[g])
                        2'd0: d = l;
                        2'd1: begin acc_m[g] = m_sat(longint'($signed(acc_m[g])) + longint'($signed(l))); d = acc_m[g]; end
                        2'd2: begin acc_m[g] = m_sat(longint'($signed(acc_m[g])) - longint'($signed(l))); d = acc_m[g]; end
                        default: begin acc_m[g] = l; d = l; end
                    endcase
                    q.push_back('{d, 2'(g)});
                    ptr_m = (g + 1) % 4;
                end
            end
        end
        chk("rnd_drained", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
